digit_display_ctrl: RTL and testbench

DIGIT_DISPLAY_CTRL -- requirements
Module: digit_display_ctrl

---
 rtl/digit_display_ctrl.sv | 103 ++++++++++
 tb/tb_digit_display_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/digit_display_ctrl.sv
// digit_display_ctrl: double-buffered 8-digit overlay with host write handshake
// and a two-stage font-ROM render pipeline driven by the VGA pixel strobe.
module digit_display_ctrl #(
    parameter int X0 = 64,
    parameter int Y0 = 208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pix_en,
    input  logic [9:0] x,
    input  logic [8:0] y,
    input  logic       valid,
    input  logic       frame_end,
    input  logic       wr_req,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_digit,
    output logic       wr_ack,
    output logic [7:0] glyph_addr,
    input  logic [7:0] glyph_data,
    output logic       pixel_on,
    output logic       pixel_valid
);
    typedef enum logic [1:0] {IDLE, ACK, COMMIT} state_t;

    state_t          state;
    logic            dirty;
    logic [7:0][3:0] shadow;
    logic [7:0][3:0] active;

    logic [7:0] dx;
    logic [5:0] dy;
    logic       in_region;
    logic [2:0] idx;
    logic [2:0] col;
    logic [3:0] row;
    logic [2:0] col_q;
    logic       in_q;
    logic       blank_q;
    logic       valid_q;

    assign dx        = x[7:0] - 8'(X0);
    assign dy        = y[5:0] - 6'(Y0);
    assign idx       = dx[7:5];
    assign col       = dx[4:2];
    assign row       = dy[5:2];
    assign in_region = valid && int'(x) >= X0 && int'(x) < X0 + 256
                             && int'(y) >= Y0 && int'(y) < Y0 + 64;

    // A pending commit wins over a simultaneous write; the write is retried next IDLE cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            dirty  <= 1'b0;
            wr_ack <= 1'b0;
            shadow <= {8{4'hF}};
            active <= {8{4'hF}};
        end else begin
            case (state)
                IDLE: begin
                    if (frame_end && dirty) begin
                        state <= COMMIT;
                    end else if (wr_req) begin
                        shadow[wr_idx] <= wr_digit;
                        dirty          <= 1'b1;
                        wr_ack         <= 1'b1;
                        state          <= ACK;
                    end
                end
                ACK: begin
                    wr_ack <= 1'b0;
                    state  <= IDLE;
                end
                COMMIT: begin
                    active <= shadow;
                    dirty  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Stage 1 consumes glyph_data fetched for the address stage 0 issued on the previous strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            glyph_addr  <= '0;
            col_q       <= '0;
            in_q        <= 1'b0;
            blank_q     <= 1'b0;
            valid_q     <= 1'b0;
            pixel_on    <= 1'b0;
            pixel_valid <= 1'b0;
        end else if (pix_en) begin
            glyph_addr  <= {active[idx], row};
            col_q       <= col;
            in_q        <= in_region;
            blank_q     <= active[idx] > 4'd9;
            valid_q     <= valid;
            pixel_on    <= in_q && !blank_q && glyph_data[3'd7 - col_q];
            pixel_valid <= valid_q;
        end
    end
endmodule

// File: tb/tb_digit_display_ctrl.sv
// tb_digit_display_ctrl: directed and randomized checks of digit_display_ctrl
// against a digit-buffer/font model computed with plain arithmetic.
module tb_digit_display_ctrl;
    localparam int X0 = 64;
    localparam int Y0 = 208;

    logic       clk = 1'b0;
    logic       reset;
    logic       pix_en;
    logic [9:0] x;
    logic [8:0] y;
    logic       valid;
    logic       frame_end;
    logic       wr_req;
    logic [2:0] wr_idx;
    logic [3:0] wr_digit;
    logic       wr_ack;
    logic [7:0] glyph_addr;
    logic [7:0] glyph_data;
    logic       pixel_on;
    logic       pixel_valid;

    digit_display_ctrl #(.X0(X0), .Y0(Y0)) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .x(x), .y(y), .valid(valid),
        .frame_end(frame_end), .wr_req(wr_req), .wr_idx(wr_idx), .wr_digit(wr_digit),
        .wr_ack(wr_ack), .glyph_addr(glyph_addr), .glyph_data(glyph_data),
        .pixel_on(pixel_on), .pixel_valid(pixel_valid)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [256];
    logic       force_ff = 1'b0;
    always @(posedge clk) glyph_data <= force_ff ? 8'hFF : rom[glyph_addr];

    int   checks = 0;
    int   errors = 0;
    int   shadow_m [8];
    int   active_m [8];
    bit   dirty_m;
    logic pend_on, pend_v;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            shadow_m[i] = 15;
            active_m[i] = 15;
        end
        dirty_m = 0;
        pend_on = 1'b0;
        pend_v  = 1'b0;
    endtask

    function automatic logic exp_pix(int xx, int yy, logic v);
        int d;
        logic [7:0] data;
        if (!v || xx < X0 || xx >= X0 + 256 || yy < Y0 || yy >= Y0 + 64) return 1'b0;
        d = active_m[(xx - X0) / 32];
        if (d > 9) return 1'b0;
        data = force_ff ? 8'hFF : rom[d * 16 + (yy - Y0) / 4];
        return data[7 - ((xx - X0) % 32) / 4];
    endfunction

    task automatic pix(int xx, int yy, logic v);
        x = 10'(xx);
        y = 9'(yy);
        valid = v;
        pix_en = 1'b1;
        tick();
        pix_en = 1'b0;
        tick();
        chk("pixel_on", 32'(pixel_on), 32'(pend_on));
        chk("pixel_valid", 32'(pixel_valid), 32'(pend_v));
        pend_on = exp_pix(xx, yy, v);
        pend_v  = v;
    endtask

    task automatic check_digit(int i);
        pix(X0 + 32 * i, Y0, 1'b1);
        chk("active_code", 32'(glyph_addr[7:4]), 32'(active_m[i]));
    endtask

    task automatic write(int i, int d, bit fe_in_ack);
        wr_idx = 3'(i);
        wr_digit = 4'(d);
        wr_req = 1'b1;
        tick();
        chk("ack_latency", 32'(wr_ack), 32'd1);
        shadow_m[i] = d;
        dirty_m = 1;
        wr_req = 1'b0;
        frame_end = fe_in_ack;
        tick();
        frame_end = 1'b0;
        chk("ack_single", 32'(wr_ack), 32'd0);
    endtask

    task automatic frame();
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        tick();
        if (dirty_m) begin
            active_m = shadow_m;
            dirty_m = 0;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
        reset = 1'b0;
        pix_en = 1'b0; x = '0; y = '0; valid = 1'b0;
        frame_end = 1'b0; wr_req = 1'b0; wr_idx = '0; wr_digit = '0;
        model_reset();
        #2;
        chk("rst_wr_ack", 32'(wr_ack), 32'd0);
        chk("rst_glyph_addr", 32'(glyph_addr), 32'd0);
        chk("rst_pixel_on", 32'(pixel_on), 32'd0);
        chk("rst_pixel_valid", 32'(pixel_valid), 32'd0);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) check_digit(i);

        // host write becomes visible only at frame_end
        write(2, 7, 0);
        check_digit(2);
        frame();
        check_digit(2);

        // render digit 1 across its first font row
        write(0, 1, 0);
        frame();
        for (int xx = 64; xx < 96; xx++) begin
            pix(xx, 208, 1'b1);
            if (xx == 64) chk("glyph_addr_10", 32'(glyph_addr), 32'h10);
        end

        // region edges and invalid pixels with an all-ones font row
        force_ff = 1'b1;
        pix(63, 210, 1'b1);
        pix(320, 210, 1'b1);
        pix(100, 207, 1'b1);
        pix(100, 272, 1'b1);
        pix(100, 220, 1'b0);
        pix(64, 208, 1'b1);
        pix(319, 271, 1'b1);
        pix(63, 210, 1'b1);
        force_ff = 1'b0;

        // blank code renders nothing
        write(5, 12, 0);
        frame();
        force_ff = 1'b1;
        for (int xx = 224; xx < 256; xx++) pix(xx, 220, 1'b1);
        force_ff = 1'b0;

        // frame_end during ACK is ignored
        write(6, 3, 1);
        check_digit(6);
        frame();
        check_digit(6);

        // collision: commit first, write acked two cycles later
        write(3, 4, 0);
        wr_idx = 3'd4; wr_digit = 4'd9; wr_req = 1'b1; frame_end = 1'b1;
        tick();
        chk("coll_ack0", 32'(wr_ack), 32'd0);
        active_m = shadow_m;
        dirty_m = 0;
        frame_end = 1'b0;
        tick();
        chk("coll_ack1", 32'(wr_ack), 32'd0);
        tick();
        chk("coll_ack2", 32'(wr_ack), 32'd1);
        shadow_m[4] = 9;
        dirty_m = 1;
        wr_req = 1'b0;
        tick();
        check_digit(3);
        check_digit(4);
        frame();
        check_digit(4);

        // randomized mix of writes, frames and pixels
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 11));
            if (r == 0) write(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 0);
            else if (r == 1) frame();
            else pix(int'($urandom_range(40, 340)), int'($urandom_range(190, 290)), 1'($urandom_range(0, 5) != 0));
        end

        // reset in ACK aborts the write
        wr_idx = 3'd1; wr_digit = 4'd2; wr_req = 1'b1;
        tick();
        chk("ack_before_rst", 32'(wr_ack), 32'd1);
        reset = 1'b0;
        #1;
        chk("rst_ack_now", 32'(wr_ack), 32'd0);
        chk("rst_pix_now", 32'(pixel_on), 32'd0);
        chk("rst_pv_now", 32'(pixel_valid), 32'd0);
        chk("rst_addr_now", 32'(glyph_addr), 32'd0);
        wr_req = 1'b0;
        tick();
        reset = 1'b1;
        model_reset();
        for (int i = 0; i < 8; i++) check_digit(i);
        frame();
        check_digit(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
